// File: rtl/fpu_add_seq_ctrl.sv
// Operand/result sequencer around a combinational FP32 adder: registers one operand pair,
// holds it for WAIT_CYCLES settle cycles, then buffers the adder SUM in a small result FIFO.
module fpu_add_seq_ctrl #(
    parameter int M_size      = 23,
    parameter int E_size      = 8,
    parameter int total_size  = 1 + E_size + M_size,
    parameter int WAIT_CYCLES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [total_size-1:0]         A_in,
    input  logic [total_size-1:0]         B_in,
    output logic [total_size-1:0]         add_A,
    output logic [total_size-1:0]         add_B,
    input  logic [total_size-1:0]         add_SUM,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [total_size-1:0]         SUM_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    fifo_wr;
    logic                    pop;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [total_size-1:0]   mem [FIFO_DEPTH];

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign SUM_out   = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        fifo_wr   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // Space is reserved at accept time, so the later write cannot overflow.
                in_ready = (level < LVL_W'(FIFO_DEPTH));
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    fifo_wr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            add_A <= '0;
            add_B <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                add_A <= A_in;
                add_B <= B_in;
                cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end else if (state == SETTLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: SUM_out is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= add_SUM;
    end

endmodule

// File: tb/tb_fpu_add_seq_ctrl.sv
// Bench for fpu_add_seq_ctrl: a behavioural FP32 adder drives add_SUM; directed vectors,
// multi-cycle corner sequences and a randomized run against a result scoreboard.
module tb_fpu_add_seq_ctrl;

    localparam int WAIT_CYCLES = 2;
    localparam int FIFO_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A_in, B_in;
    logic [31:0] add_A, add_B, add_SUM;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SUM_out;
    logic        busy;
    logic [2:0]  level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_add_seq_ctrl #(
        .M_size(23), .E_size(8), .total_size(32),
        .WAIT_CYCLES(WAIT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A_in(A_in), .B_in(B_in), .add_A(add_A), .add_B(add_B), .add_SUM(add_SUM),
        .out_valid(out_valid), .out_ready(out_ready), .SUM_out(SUM_out),
        .busy(busy), .level(level)
    );

    function automatic real fp_to_real(input logic [31:0] f);
        real r;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        r = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return f[31] ? -r : r;
    endfunction

    function automatic logic [31:0] real_to_fp(input real x);
        logic s;
        real  r;
        int   e;
        int   m;
        if (x == 0.0) return 32'd0;
        s = (x < 0.0);
        r = s ? -x : x;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0)  begin r = r * 2.0; e--; end
        m = $rtoi((r - 1.0) * 8388608.0);
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_fp(fp_to_real(a) + fp_to_real(b));
    endfunction

    // Stand-in for the combinational adder hanging off add_A/add_B.
    assign add_SUM = fp_add(add_A, add_B);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns once the pair has been taken at a clock edge (or the wait budget ran out).
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 0;
        A_in = a;
        B_in = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin ok = 1; break; end
            tick();
        end
        if (ok) tick();
        in_valid = 1'b0;
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin ok = 1; break; end
            tick();
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] sb[$];
    localparam int NRAND = 12;

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'($urandom_range(134, 120)), r[22:0]};
    endfunction

    initial begin
        vecs[0] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[1] = '{32'h3FC00000, 32'h3F000000, 32'h40000000};
        vecs[2] = '{32'h40000000, 32'h3F800000, 32'h40400000};
        vecs[3] = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[4] = '{32'h3F000000, 32'h3E800000, 32'h3F400000};
        vecs[5] = '{32'h40800000, 32'h40800000, 32'h41000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A_in = '0; B_in = '0;
        #23;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum_out", SUM_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_add_A", add_A, 32'd0);
        check("rst_add_B", add_B, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with the consumer always ready.
        for (int v = 0; v < 6; v++) begin
            int n;
            bit seen;
            out_ready = 1'b1;
            issue(vecs[v].a, vecs[v].b);
            n = 0; seen = 0;
            for (int i = 0; i < 20; i++) begin
                n++;
                if (out_valid) begin seen = 1; break; end
                tick();
            end
            // n counts edges after the accepting edge (sampled n-1 edges later plus the first).
            check($sformatf("vec%0d_latency", v), 32'(n - 1), 32'(WAIT_CYCLES));
            check($sformatf("vec%0d_seen", v), 32'(seen), 32'd1);
            check($sformatf("vec%0d_sum", v), SUM_out, vecs[v].sum);
            check($sformatf("vec%0d_level1", v), 32'(level), 32'd1);
            tick();
            check($sformatf("vec%0d_level0", v), 32'(level), 32'd0);
            out_ready = 1'b0;
        end

        // Operands stay on the adder inputs for the whole settle window.
        issue(32'h3FC00000, 32'h3F000000);
        for (int i = 0; i < WAIT_CYCLES; i++) begin
            check("settle_busy", 32'(busy), 32'd1);
            check("settle_in_ready", 32'(in_ready), 32'd0);
            check("settle_add_A", add_A, 32'h3FC00000);
            check("settle_add_B", add_B, 32'h3F000000);
            tick();
        end
        check("settle_done_busy", 32'(busy), 32'd0);
        check("settle_sum", SUM_out, 32'h40000000);
        pop_one();
        check("settle_level0", 32'(level), 32'd0);

        // Fill the FIFO with the consumer stalled, then drain in order.
        for (int i = 0; i < FIFO_DEPTH; i++) issue(vecs[i + 2].a, vecs[i + 2].b);
        wait_idle();
        check("full_level", 32'(level), 32'(FIFO_DEPTH));
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", SUM_out, vecs[2].sum);
        pop_one();
        check("full_pop_level", 32'(level), 32'(FIFO_DEPTH - 1));
        check("full_pop_in_ready", 32'(in_ready), 32'd1);
        for (int i = 1; i < FIFO_DEPTH; i++) begin
            check($sformatf("drain%0d", i), SUM_out, vecs[i + 2].sum);
            pop_one();
        end
        check("drain_empty", 32'(level), 32'd0);
        check("drain_sum_zero", SUM_out, 32'd0);

        // Pop on the same edge as the FIFO write.
        issue(vecs[2].a, vecs[2].b);
        wait_idle();
        issue(vecs[5].a, vecs[5].b);
        repeat (WAIT_CYCLES - 1) tick();
        check("simul_pre_level", 32'(level), 32'd1);
        pop_one();
        check("simul_level", 32'(level), 32'd1);
        check("simul_head", SUM_out, vecs[5].sum);
        pop_one();
        check("simul_empty", 32'(level), 32'd0);

        // Asynchronous reset in the middle of a settle window with results buffered.
        issue(vecs[0].a, vecs[0].b);
        wait_idle();
        issue(vecs[2].a, vecs[2].b);
        wait_idle();
        issue(vecs[4].a, vecs[4].b);
        check("prerst_level", 32'(level), 32'd2);
        check("prerst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_add_A", add_A, 32'd0);
        check("midrst_add_B", add_B, 32'd0);
        check("midrst_sum", SUM_out, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue(vecs[5].a, vecs[5].b);
        wait_idle();
        check("postrst_level", 32'(level), 32'd1);
        check("postrst_sum", SUM_out, vecs[5].sum);
        pop_one();

        // Randomized traffic: ptrs wrap several times, consumer stalls at random.
        sb.delete();
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    logic [31:0] a, b;
                    a = rand_fp();
                    b = rand_fp();
                    issue(a, b);
                    sb.push_back(fp_add(a, b));
                end
            end
            begin
                int got;
                got = 0;
                for (int c = 0; c < 2000 && got < NRAND; c++) begin
                    out_ready = 1'($urandom_range(1, 0));
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            check("rand_unexpected", SUM_out, 32'd0);
                        end else begin
                            check($sformatf("rand%0d", got), SUM_out, sb.pop_front());
                        end
                        got++;
                    end
                    tick();
                end
                out_ready = 1'b0;
                check("rand_count", 32'(got), 32'(NRAND));
            end
        join
        check("rand_sb_empty", 32'(sb.size()), 32'd0);
        check("rand_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
